// File: rtl/mult8_acc.sv
// rtl/mult8_acc.sv - saturating burst accumulator for mult8 products
module mult8_acc #(
   parameter int IN_W  = 16,
   parameter int ACC_W = 24,
   parameter int LEN   = 4
) (
   input  logic             clk,
   input  logic             sig,
   input  logic             start,
   input  logic             pvalid,
   input  logic [IN_W-1:0]  inp,
   output logic [ACC_W-1:0] out,
   output logic             valid,
   output logic             busy,
   output logic             ovf
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   // Index of the product that closes a burst; cnt never needs to go past it.
   localparam logic [7:0] LAST = 8'(LEN - 1);

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [7:0]       cnt;

   logic [ACC_W:0]   inp_ext;
   logic [ACC_W:0]   sum_wide;
   logic [ACC_W-1:0] sum_sat;
   logic             sum_ovf;

   // One extra bit of headroom exposes the carry; a carry means saturate.
   always_comb begin
      inp_ext  = {{(ACC_W + 1 - IN_W){1'b0}}, inp};
      sum_wide = {1'b0, acc} + inp_ext;
      sum_ovf  = sum_wide[ACC_W];
      sum_sat  = sum_ovf ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
   end

   // Burst control: start always opens a fresh burst, pvalid only counts inside one.
   always_ff @(posedge clk or posedge sig) begin
      if (sig) begin
         state <= S_IDLE;
         acc   <= '0;
         cnt   <= '0;
         out   <= '0;
         valid <= 1'b0;
         busy  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  acc   <= '0;
                  cnt   <= '0;
                  ovf   <= 1'b0;
                  busy  <= 1'b1;
                  state <= S_ACC;
               end
            end

            S_ACC: begin
               if (start) begin
                  // Abort/restart: a product arriving with start is dropped.
                  acc <= '0;
                  cnt <= '0;
                  ovf <= 1'b0;
               end else if (pvalid) begin
                  acc <= sum_sat;
                  cnt <= cnt + 8'd1;
                  ovf <= ovf | sum_ovf;
                  if (cnt == LAST) begin
                     out   <= sum_sat;
                     valid <= 1'b1;
                     busy  <= 1'b0;
                     state <= S_HOLD;
                  end
               end
            end

            S_HOLD: begin
               // out stays on the old result until the next burst completes.
               if (start) begin
                  valid <= 1'b0;
                  acc   <= '0;
                  cnt   <= '0;
                  ovf   <= 1'b0;
                  busy  <= 1'b1;
                  state <= S_ACC;
               end
            end

            default: begin
               state <= S_IDLE;
               valid <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
